// File: rtl/seq_engine.sv
// seq_engine: memory-game sequencer. Entries are appended from a free-running
// seed, played back one at a time for HOLD cycles each with a one-cycle gap,
// then the player's guesses are checked in order until a win or a loss.
//
// Optional feature macro: SEQ_ENGINE_SCORE_EN adds the `best` output, which is
// the longest sequence length at which a win was reached since reset.
//
// Ports:
//   Clk          rising-edge clock
//   Rst          synchronous active-high reset
//   seed[3:0]    value appended on add
//   add          pulse: append seed (IDLE only, ignored when full)
//   play         pulse: start playback (IDLE only, length>0, no add same cycle)
//   guess_valid  pulse: guess present (CHECK only)
//   guess[3:0]   player guess
//   ack          pulse: acknowledge win/lose
//   show[3:0]    entry being displayed (0 when not showing)
//   show_valid   show is meaningful
//   length[3:0]  stored entry count
//   full         length == DEPTH
//   busy         state is not IDLE
//   win, lose    in WIN / in LOSE
//   best[3:0]    (SEQ_ENGINE_SCORE_EN only) best winning length
module seq_engine #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned HOLD  = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] seed,
  input  logic       add,
  input  logic       play,
  input  logic       guess_valid,
  input  logic [3:0] guess,
  input  logic       ack,
  output logic [3:0] show,
  output logic       show_valid,
  output logic [3:0] length,
  output logic       full,
  output logic       busy,
  output logic       win,
  output logic       lose
`ifdef SEQ_ENGINE_SCORE_EN
  ,
  output logic [3:0] best
`endif
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHOW  = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_WIN   = 3'd4;
  localparam logic [2:0] S_LOSE  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    len_q, len_d;
  logic [3:0]    show_q, show_d;
  logic          show_valid_q, show_valid_d;
  logic          busy_q, busy_d;
  logic          win_q, win_d;
  logic          lose_q, lose_d;
  logic [3:0]    mem_q [DEPTH];

  logic          full_c;
  logic          mem_wr_c;
  logic [IW-1:0] last_idx_c;

  assign full_c     = (len_q == 4'(DEPTH));
  assign mem_wr_c   = (state_q == S_IDLE) && add && !full_c;
  // Only consulted in SHOW/GAP/CHECK, where length is at least 1.
  assign last_idx_c = IW'(len_q - 4'd1);

  // Sequence storage; deliberately not reset (unreachable while length is 0).
  always_ff @(posedge Clk) begin
    if (!Rst && mem_wr_c) begin
      mem_q[len_q[IW-1:0]] <= seed;
    end
  end

  // State and counter registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      hold_q       <= '0;
      len_q        <= '0;
      show_q       <= '0;
      show_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      len_q        <= len_d;
      show_q       <= show_d;
      show_valid_q <= show_valid_d;
      busy_q       <= busy_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
    end
  end

  // Next-state logic; outputs are precomputed from the next state so they
  // register in step with it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    len_d   = len_q;

    case (state_q)
      S_IDLE: begin
        if (add && !full_c) begin
          len_d = len_q + 4'd1;
        end
        if (play && !add && (len_q != 4'd0)) begin
          state_d = S_SHOW;
          idx_d   = '0;
          hold_d  = '0;
        end
      end
      S_SHOW: begin
        if (hold_q == HW'(HOLD - 1)) begin
          state_d = S_GAP;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_GAP: begin
        if (idx_q == last_idx_c) begin
          state_d = S_CHECK;
          idx_d   = '0;
        end else begin
          state_d = S_SHOW;
          idx_d   = idx_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (guess_valid) begin
          if (guess == mem_q[idx_q]) begin
            if (idx_q == last_idx_c) begin
              state_d = S_WIN;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            state_d = S_LOSE;
            idx_d   = '0;
          end
        end
      end
      S_WIN: begin
        if (ack) begin
          state_d = S_IDLE;
        end
      end
      S_LOSE: begin
        if (ack) begin
          state_d = S_IDLE;
          len_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        hold_d  = '0;
      end
    endcase

    show_valid_d = (state_d == S_SHOW);
    show_d       = (state_d == S_SHOW) ? mem_q[idx_d] : 4'd0;
    busy_d       = (state_d != S_IDLE);
    win_d        = (state_d == S_WIN);
    lose_d       = (state_d == S_LOSE);
  end

`ifdef SEQ_ENGINE_SCORE_EN
  logic [3:0] best_q;

  // Captures length on entry to WIN when it beats the previous best.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      best_q <= '0;
    end else if ((state_d == S_WIN) && (state_q != S_WIN) && (len_q > best_q)) begin
      best_q <= len_q;
    end
  end

  assign best = best_q;
`endif

  assign show       = show_q;
  assign show_valid = show_valid_q;
  assign length     = len_q;
  assign full       = full_c;
  assign busy       = busy_q;
  assign win        = win_q;
  assign lose       = lose_q;

endmodule

// File: tb/tb_seq_engine.sv
// Directed bench for seq_engine (DEPTH=8, HOLD=4): a vector table for the
// idle/add/full/reset behaviour plus hand-written playback, check, win, lose
// and mid-playback reset sequences.
module tb_seq_engine;

  localparam int unsigned HOLD = 4;

  logic       Clk;
  logic       Rst;
  logic [3:0] seed;
  logic       add;
  logic       play;
  logic       guess_valid;
  logic [3:0] guess;
  logic       ack;
  logic [3:0] show;
  logic       show_valid;
  logic [3:0] length;
  logic       full;
  logic       busy;
  logic       win;
  logic       lose;
`ifdef SEQ_ENGINE_SCORE_EN
  logic [3:0] best;
`endif

  seq_engine #(.DEPTH(8), .HOLD(HOLD)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .seed(seed),
    .add(add),
    .play(play),
    .guess_valid(guess_valid),
    .guess(guess),
    .ack(ack),
    .show(show),
    .show_valid(show_valid),
    .length(length),
    .full(full),
    .busy(busy),
    .win(win),
    .lose(lose)
`ifdef SEQ_ENGINE_SCORE_EN
    ,
    .best(best)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic       add;
    logic       play;
    logic [3:0] seed;
    logic       gv;
    logic [3:0] guess;
    logic       ack;
    logic [3:0] exp_len;
    logic       exp_full;
    logic       exp_busy;
    logic       exp_sv;
    logic [3:0] exp_show;
    logic       exp_win;
    logic       exp_lose;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_fail;

  function automatic vec_t mk(input logic r, input logic a, input logic p,
                              input logic [3:0] s, input logic g,
                              input logic [3:0] gu, input logic k,
                              input logic [3:0] l, input logic f, input logic b);
    vec_t v;
    v.rst = r; v.add = a; v.play = p; v.seed = s; v.gv = g; v.guess = gu;
    v.ack = k; v.exp_len = l; v.exp_full = f; v.exp_busy = b;
    v.exp_sv = 1'b0; v.exp_show = 4'd0; v.exp_win = 1'b0; v.exp_lose = 1'b0;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, sample #1 after the edge, clear pulses.
  task automatic step(input logic r, input logic a, input logic p,
                      input logic [3:0] s, input logic g,
                      input logic [3:0] gu, input logic k);
    Rst = r; add = a; play = p; seed = s; guess_valid = g; guess = gu; ack = k;
    @(posedge Clk);
    #1;
    Rst = 1'b0; add = 1'b0; play = 1'b0; guess_valid = 1'b0; ack = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] e_show,
                            input logic e_sv, input logic [3:0] e_len,
                            input logic e_busy, input logic e_win,
                            input logic e_lose);
    chk({tag, "_show"}, int'(show), int'(e_show));
    chk({tag, "_show_valid"}, int'(show_valid), int'(e_sv));
    chk({tag, "_length"}, int'(length), int'(e_len));
    chk({tag, "_busy"}, int'(busy), int'(e_busy));
    chk({tag, "_win"}, int'(win), int'(e_win));
    chk({tag, "_lose"}, int'(lose), int'(e_lose));
  endtask

  // Plays back `seq` after a play pulse, checking every SHOW and GAP cycle.
  task automatic run_playback(input string tag, input logic [3:0] s0,
                              input logic [3:0] s1, input logic [3:0] s2,
                              input logic [3:0] s3, input int n,
                              input logic [3:0] len);
    logic [3:0] seq [4];
    seq[0] = s0; seq[1] = s1; seq[2] = s2; seq[3] = s3;
    step(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    for (int e = 0; e < n; e++) begin
      for (int h = 0; h < int'(HOLD); h++) begin
        expect_out($sformatf("%s_e%0d_h%0d", tag, e, h), seq[e], 1'b1, len,
                   1'b1, 1'b0, 1'b0);
        idle();
      end
      expect_out($sformatf("%s_gap%0d", tag, e), 4'd0, 1'b0, len, 1'b1, 1'b0,
                 1'b0);
      idle();
    end
    expect_out({tag, "_check"}, 4'd0, 1'b0, len, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Rst = 1'b0; add = 1'b0; play = 1'b0; seed = 4'd0;
    guess_valid = 1'b0; guess = 4'd0; ack = 1'b0;

    // Reset then 5 idle cycles.
    vecs.push_back(mk(1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0));
    // Nine adds: the ninth is dropped once full.
    for (int i = 1; i <= 9; i++) begin
      vecs.push_back(mk(0, 1, 0, 4'(i), 0, 4'd0, 0, 4'((i > 8) ? 8 : i),
                        (i >= 8) ? 1'b1 : 1'b0, 0));
    end
    // guess_valid / ack in IDLE have no effect.
    vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4'd1, 1, 4'd8, 1, 0));
    // Reset beats a simultaneous add.
    vecs.push_back(mk(1, 1, 0, 4'd5, 0, 4'd0, 0, 4'd0, 0, 0));
    // play with empty sequence is ignored.
    vecs.push_back(mk(0, 0, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'd5, 0, 4'd0, 0, 4'd1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'd6, 0, 4'd0, 0, 4'd2, 0, 0));
    // add+play together: add executes, no playback.
    vecs.push_back(mk(0, 1, 1, 4'd7, 0, 4'd0, 0, 4'd3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'd0, 0, 4'd0, 0, 4'd3, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].add, vecs[i].play, vecs[i].seed, vecs[i].gv,
           vecs[i].guess, vecs[i].ack);
      chk($sformatf("vec%0d_length", i), int'(length), int'(vecs[i].exp_len));
      chk($sformatf("vec%0d_full", i), int'(full), int'(vecs[i].exp_full));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_show_valid", i), int'(show_valid), int'(vecs[i].exp_sv));
      chk($sformatf("vec%0d_show", i), int'(show), int'(vecs[i].exp_show));
      chk($sformatf("vec%0d_win", i), int'(win), int'(vecs[i].exp_win));
      chk($sformatf("vec%0d_lose", i), int'(lose), int'(vecs[i].exp_lose));
    end

    // Winning round with 3, 9, 12.
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd12, 1'b0, 4'd0, 1'b0);
    expect_out("loaded", 4'd0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
    run_playback("pb_win", 4'd3, 4'd9, 4'd12, 4'd0, 3, 4'd3);
    // add/play ignored while in CHECK.
    step(1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0);
    expect_out("chk_add_ign", 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd3, 1'b0);
    expect_out("g0", 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd9, 1'b0);
    expect_out("g1", 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd12, 1'b0);
    expect_out("g2_win", 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0);
    idle();
    expect_out("win_hold", 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
    expect_out("win_ack", 4'd0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);

    // Extend to 4 entries and lose on the second guess.
    step(1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 4'd0, 1'b0);
    expect_out("add4", 4'd0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0);
    run_playback("pb_lose", 4'd3, 4'd9, 4'd12, 4'd5, 4, 4'd4);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd3, 1'b0);
    expect_out("l0", 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd7, 1'b0);
    expect_out("l1_lose", 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b1);
    idle();
    expect_out("lose_hold", 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b1);
`ifdef SEQ_ENGINE_SCORE_EN
    chk("best_after_lose", int'(best), 3);
`endif
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
    expect_out("lose_ack", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Reset during the third SHOW cycle.
    step(1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd12, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    expect_out("rs_show1", 4'd3, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    expect_out("rs_show3", 4'd3, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    expect_out("rs_after", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("rs_full", int'(full), 0);
    step(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    expect_out("rs_play_empty", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_engine.md
SEQ_ENGINE -- requirements
Module: seq_engine

Interface
REQ-001 Parameter DEPTH, default 8, meaning max sequence entries (power of 2, 2..8).
REQ-002 Parameter HOLD, default 4, meaning clock cycles each entry is shown during playback (1..255).
REQ-003 Clk  input  1  rising-edge clock, the only clock.
REQ-004 Rst  input  1  reset, synchronous and active-high.
REQ-005 seed  input  4  free-running 0-15 value from the upstream counter, sampled on add.
REQ-006 add  input  1  single-cycle pulse: append seed to sequence.
REQ-007 play  input  1  single-cycle pulse: start playback of stored sequence.
REQ-008 guess_valid  input  1  single-cycle pulse: player guess present.
REQ-009 guess  input  4  player guess value.
REQ-010 ack  input  1  single-cycle pulse: acknowledge win/lose result.
REQ-011 show  output  4  entry currently displayed.
REQ-012 show_valid  output  1  show is meaningful this cycle.
REQ-013 length  output  4  stored entry count, 0..DEPTH.
REQ-014 full, busy, win, lose  output  1 each  length==DEPTH; state!=IDLE; in WIN; in LOSE.

Function
REQ-015 States: IDLE, SHOW, GAP, CHECK, WIN, LOSE; one-hot or encoded is free, but only these six are reachable.
REQ-016 IDLE, add, length<DEPTH: mem[length]<=seed, length+1 at that edge.
REQ-017 IDLE, add, full: ignored; length and mem unchanged.
REQ-018 IDLE, play, length>0, no add same cycle: next state SHOW, idx=0, hold counter=0.
REQ-019 IDLE, play with length==0, or add and play in the same cycle: play ignored (add still executes).
REQ-020 SHOW: show=mem[idx], show_valid=1 for exactly HOLD cycles, then GAP.
REQ-021 GAP: one cycle, show_valid=0, show=0; if idx==length-1 go CHECK with idx=0, else idx+1 and back to SHOW.
REQ-022 First show_valid cycle is the cycle after the play edge (latency 1).
REQ-023 CHECK, guess_valid, guess==mem[idx]: idx==length-1 -> WIN, else idx+1, stay CHECK.
REQ-024 CHECK, guess_valid, guess!=mem[idx]: LOSE next cycle.
REQ-025 WIN: win=1 until ack, then IDLE; sequence and length retained so the player can add one more entry.
REQ-026 LOSE: lose=1 until ack, then IDLE with length cleared to 0.
REQ-027 add, play ignored outside IDLE; guess_valid ignored outside CHECK; ack ignored outside WIN/LOSE.
REQ-028 busy=1 in every state except IDLE; full combinational from length.
REQ-029 idx and hold counter widths sized to DEPTH and HOLD; no wrap past length-1 or HOLD-1.

Reset
REQ-030 Rst at any edge, in any state (including mid-playback or mid-check): next state IDLE, length=0, idx=0, hold=0, show=0, show_valid=0, win=0, lose=0, busy=0, full=0.
REQ-031 Rst has priority over every other input in the same cycle; mem contents not reset (unreachable while length=0).

Configuration
REQ-032 Macro SEQ_ENGINE_SCORE_EN: when defined, adds output best [3:0], the largest length at which WIN was reached since reset, updated on WIN entry, reset to 0.
REQ-033 Without SEQ_ENGINE_SCORE_EN: no best port, no score register; all other behaviour identical.

Verification
REQ-034 Rst 1 cycle, then idle 5 cycles -> all outputs 0, length=0, state IDLE.
REQ-035 add with seed 3,9,12 on 3 separate cycles, play -> show 3,9,12 each HOLD=4 cycles with show_valid, 1-cycle gaps, then CHECK; guesses 3,9,12 -> win=1; ack -> IDLE, length=3.
REQ-036 Same sequence, guesses 3,7 -> lose=1 after second guess; ack -> length=0.
REQ-037 9 add pulses (DEPTH=8) -> length=8, full=1, ninth seed not stored; add+play same cycle at length=2 -> length=3, no playback.
REQ-038 Rst asserted in 3rd SHOW cycle -> next cycle IDLE, show_valid=0, length=0; play with length=0 -> stays IDLE.
REQ-039 With SEQ_ENGINE_SCORE_EN: win at length 3 then lose at length 4 -> best=3; without the macro the build has no best port.
